// File: rtl/adc_capture_trig.sv
// Triggered two-channel ADC capture into on-chip RAM, with pipelined 16-bit readback over row/col/sel.
module adc_capture_trig #(
  parameter int unsigned GPIO_DATA_WIDTH = 16,
  parameter int unsigned RAM_DATA_WIDTH  = 128,
  parameter int unsigned ADC_DATA_WIDTH  = 256,
  parameter int unsigned RAM_DEPTH       = 12
) (
  input  logic                       s00_axis_aclk,
  input  logic                       s00_axis_areset,
  input  logic [ADC_DATA_WIDTH-1:0]  s00_axis_tdata,
  input  logic                       s00_axis_tvalid,
  output logic                       s00_axis_tready,
  input  logic                       arm,
  input  logic                       control_trigger,
  input  logic [31:0]                trig_delay,
  input  logic [31:0]                num_points,
  input  logic [RAM_DEPTH-1:0]       row,
  input  logic [2:0]                 col,
  input  logic                       sel,
  input  logic                       rd_req,
  output logic [GPIO_DATA_WIDTH-1:0] gpio_data_out,
  output logic                       rd_valid,
  output logic                       busy,
  output logic                       done,
  output logic [RAM_DEPTH:0]         capture_count
);

  localparam int unsigned CW    = RAM_DEPTH + 1;
  localparam int unsigned WORDS = 2**RAM_DEPTH;

  typedef enum logic [2:0] {IDLE, ARMED, DELAY, CAPTURE, DONE} state_t;

  state_t                    state_q, state_d;
  logic                      trig_prev_q;
  logic                      tready_q;
  logic [31:0]               delay_q, delay_d;
  logic [CW-1:0]             len_q, len_d;
  logic [31:0]               dcnt_q, dcnt_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic                      trig_edge_c;
  logic                      beat_c;
  logic                      we_c;
  logic [CW-1:0]             len_clip_c;
  logic [CW-1:0]             cnt_inc_c;
  logic                      rd_ok_c;

  logic                      req_v_q;
  logic [RAM_DEPTH-1:0]      req_row_q;
  logic [2:0]                req_col_q, s1_col_q;
  logic                      req_sel_q, s1_sel_q;
  logic                      s1_v_q;
  logic                      rd_valid_q;
  logic [GPIO_DATA_WIDTH-1:0] gpio_q;
  logic [RAM_DATA_WIDTH-1:0] rd0_q, rd1_q;
  logic [RAM_DATA_WIDTH-1:0] rd_word_c;

  logic [RAM_DATA_WIDTH-1:0] ram0 [WORDS];
  logic [RAM_DATA_WIDTH-1:0] ram1 [WORDS];

  assign trig_edge_c = control_trigger && !trig_prev_q;
  assign beat_c      = s00_axis_tvalid && tready_q;
  assign len_clip_c  = (num_points > 32'(WORDS)) ? CW'(WORDS) : CW'(num_points);
  assign cnt_inc_c   = cnt_q + CW'(1);
  assign rd_ok_c     = rd_req && ((state_q == IDLE) || (state_q == DONE));

  // Next-state logic; arm overrides every state, including a simultaneous trigger edge.
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    len_d   = len_q;
    dcnt_d  = dcnt_q;
    cnt_d   = cnt_q;
    we_c    = 1'b0;
    if (arm) begin
      state_d = ARMED;
      delay_d = trig_delay;
      len_d   = len_clip_c;
      dcnt_d  = 32'd1;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (trig_edge_c) begin
            dcnt_d = 32'd1;
            if (delay_q != '0)      state_d = DELAY;
            else if (len_q == '0)   state_d = DONE;
            else                    state_d = CAPTURE;
          end
        end
        DELAY: begin
          if (dcnt_q == delay_q) state_d = (len_q == '0) ? DONE : CAPTURE;
          else                   dcnt_d  = dcnt_q + 32'd1;
        end
        CAPTURE: begin
          if (beat_c) begin
            we_c  = 1'b1;
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == len_q) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == ARMED) || (state_d == DELAY) || (state_d == CAPTURE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q     <= IDLE;
      trig_prev_q <= 1'b0;
      tready_q    <= 1'b0;
      delay_q     <= '0;
      len_q       <= '0;
      dcnt_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= control_trigger;
      tready_q    <= 1'b1;
      delay_q     <= delay_d;
      len_q       <= len_d;
      dcnt_q      <= dcnt_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Channel RAMs: capture writes and registered readback (never active in the same state).
  always_ff @(posedge s00_axis_aclk) begin
    if (we_c) begin
      ram0[cnt_q[RAM_DEPTH-1:0]] <= s00_axis_tdata[RAM_DATA_WIDTH-1:0];
      ram1[cnt_q[RAM_DEPTH-1:0]] <= s00_axis_tdata[ADC_DATA_WIDTH-1 -: RAM_DATA_WIDTH];
    end
    if (req_v_q) begin
      rd0_q <= ram0[req_row_q];
      rd1_q <= ram1[req_row_q];
    end
  end

  assign rd_word_c = s1_sel_q ? rd1_q : rd0_q;

  // Readback pipeline: request register, RAM register, sample-mux register.
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      req_v_q    <= 1'b0;
      req_row_q  <= '0;
      req_col_q  <= '0;
      req_sel_q  <= 1'b0;
      s1_v_q     <= 1'b0;
      s1_col_q   <= '0;
      s1_sel_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      gpio_q     <= '0;
    end else begin
      req_v_q    <= rd_ok_c;
      if (rd_ok_c) begin
        req_row_q <= row;
        req_col_q <= col;
        req_sel_q <= sel;
      end
      s1_v_q     <= req_v_q;
      s1_col_q   <= req_col_q;
      s1_sel_q   <= req_sel_q;
      rd_valid_q <= s1_v_q;
      if (s1_v_q) gpio_q <= rd_word_c[s1_col_q*GPIO_DATA_WIDTH +: GPIO_DATA_WIDTH];
    end
  end

  assign s00_axis_tready = tready_q;
  assign gpio_data_out   = gpio_q;
  assign rd_valid        = rd_valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign capture_count   = cnt_q;

endmodule
